// File: rtl/vga_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : vga_pkg
// Brief   : 640x480 timing constants, {r3,g3,b2} colour-field offsets and a
//           shift-add row-base helper shared by the video blocks.
// Revision: 1.0
//------------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int H_TOTAL        = 800;
  localparam int V_ACTIVE       = 480;
  localparam int V_TOTAL        = 525;
  localparam int BYTES_PER_LINE = H_ACTIVE / 8;

  localparam int RED_LSB   = 5;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_LSB  = 0;

  // row * BYTES_PER_LINE (80 = 64 + 16) as two shifts and an add.
  function automatic logic [15:0] row_base(input logic [9:0] row);
    return ({6'd0, row} << 6) + ({6'd0, row} << 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : vga_scanout_if
// Brief   : Video read port of vram: registered byte address out, byte back.
// Revision: 1.0
//------------------------------------------------------------------------------
interface vga_scanout_if;

  logic [15:0] vram_addr;
  logic [7:0]  vram_data;

  modport master (output vram_addr, input  vram_data);
  modport slave  (input  vram_addr, output vram_data);

endinterface
`default_nettype wire

// File: rtl/vga_scanout_fetch.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : scan_fetch
// Brief   : Keeps one frame-buffer byte in flight ahead of the beam; owns the
//           line-base registers, vram address, read-valid pipe and next_byte.
// Revision: 1.0
//------------------------------------------------------------------------------
module scan_fetch
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  vga_scanout_if.master vram,
  output logic [7:0]    next_byte
);

  if (RD_LAT < 1 || RD_LAT > 5) begin : g_bad_rd_lat
    $error("scan_fetch: RD_LAT must be in 1..5");
  end

  logic              w_in_range;
  logic [9:0]        w_row_next;
  logic              w_mid_fetch;
  logic              w_line_slot;
  logic              w_line_fetch;
  logic              w_fetch;
  logic [15:0]       w_mid_addr;

  logic [15:0]       r_addr;
  logic [15:0]       r_line_base;
  logic [15:0]       r_next_base;
  logic [RD_LAT-1:0] r_vld;
  logic [7:0]        r_next_byte;
  logic              r_armed;

  assign w_in_range   = (x < 10'(H_TOTAL)) && (y < 10'(V_TOTAL));
  assign w_row_next   = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
  // After a reset mid-line the line base is unknown, so mid-line fetches wait
  // for the next-line slot to re-arm them.
  assign w_mid_fetch  = r_armed && (x[2:0] == 3'd1) && (x < 10'(H_ACTIVE - 8))
                        && (y < 10'(V_ACTIVE));
  assign w_line_slot  = w_in_range && (x == 10'(H_TOTAL - 8));
  assign w_line_fetch = w_line_slot && (w_row_next < 10'(V_ACTIVE));
  assign w_fetch      = w_mid_fetch || w_line_fetch;
  assign w_mid_addr   = r_line_base + 16'(x[9:3]) + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_line_base <= '0;
      r_next_base <= '0;
      r_vld       <= '0;
      r_next_byte <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_vld <= (r_vld << 1) | RD_LAT'(w_fetch);
      if (w_fetch) begin
        r_addr <= w_mid_fetch ? w_mid_addr : r_next_base;
      end
      if (r_vld[RD_LAT-1]) begin
        r_next_byte <= vram.vram_data;
      end else if (w_line_slot && !w_line_fetch) begin
        r_next_byte <= 8'h00;
      end
      if (w_line_slot) begin
        r_armed <= 1'b1;
      end
      // Re-seeded once per line in blanking so a mid-frame reset recovers
      // by the following line; the running increment below covers the rest.
      if (w_in_range && (x == 10'(H_TOTAL - 16))) begin
        r_next_base <= row_base(w_row_next);
      end
      if (w_in_range && (x == 10'(H_TOTAL - 1))) begin
        if (y == 10'(V_TOTAL - 1)) begin
          r_line_base <= '0;
          r_next_base <= 16'(BYTES_PER_LINE);
        end else begin
          r_line_base <= r_next_base;
          if (w_row_next < 10'(V_ACTIVE - 1)) begin
            r_next_base <= r_next_base + 16'(BYTES_PER_LINE);
          end
        end
      end
    end
  end

  assign vram.vram_addr = r_addr;
  assign next_byte      = r_next_byte;

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : vga_scanout
// Brief   : 1-bpp frame buffer to registered RGB332 plus 1-clk delayed syncs.
// Revision: 1.0
//------------------------------------------------------------------------------
module vga_scanout
  import vga_pkg::*;
#(
  parameter int         RD_LAT = 1,
  parameter logic [7:0] FG     = 8'hFF,
  parameter logic [7:0] BG     = 8'h00
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          vidon,
  input  logic          hsync_in,
  input  logic          vsync_in,
  vga_scanout_if.master vram,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue,
  output logic          hsync,
  output logic          vsync
);

  logic [7:0] w_next_byte;
  logic       w_in_range;
  logic [7:0] w_colour;

  logic [7:0] r_cur_byte;
  logic [7:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;

  scan_fetch #(
    .RD_LAT    (RD_LAT)
  ) u_fetch (
    .clk       (clk),
    .resetn    (resetn),
    .x         (x),
    .y         (y),
    .vram      (vram),
    .next_byte (w_next_byte)
  );

  assign w_in_range = (x < 10'(H_TOTAL)) && (y < 10'(V_TOTAL));

  // Bit i of the byte is the pixel at x[2:0] = i (LSB leftmost).
  always_comb begin
    w_colour = 8'h00;
    if (vidon && w_in_range) begin
      w_colour = r_cur_byte[x[2:0]] ? FG : BG;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur_byte <= '0;
      r_rgb      <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
    end else begin
      if (w_in_range && (x[2:0] == 3'd7)) begin
        r_cur_byte <= w_next_byte;
      end
      r_rgb   <= w_colour;
      r_hsync <= hsync_in;
      r_vsync <= vsync_in;
    end
  end

  assign red   = r_rgb[RED_LSB   +: 3];
  assign green = r_rgb[GREEN_LSB +: 3];
  assign blue  = r_rgb[BLUE_LSB  +: 2];
  assign hsync = r_hsync;
  assign vsync = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : tb_vga_scanout
// Brief   : Directed bench driving x/y directly; RD_LAT=1..5 instances share
//           one frame buffer and are compared against a frame-buffer model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int         N_INST = 5;
  localparam logic [7:0] TB_FG  = 8'hFF;
  localparam logic [7:0] TB_BG  = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [9:0] x;
  logic [9:0] y;
  logic       vidon;
  logic       hsync_in;
  logic       vsync_in;

  logic [7:0]  mem [0:65535];
  logic [7:0]  glyph [7];
  logic [9:0]  obs [N_INST];
  logic [15:0] addr_obs [N_INST];
  logic [9:0]  sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar k = 0; k < N_INST; k++) begin : g_inst
    vga_scanout_if u_if ();
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        hsync;
    logic        vsync;
    logic [15:0] ahist [1:4];
    logic [15:0] rd_addr;

    // vram model: data for the address driven at edge t is valid at edge t+RD_LAT
    always @(posedge clk) begin
      ahist[1] <= u_if.vram_addr;
      for (int j = 2; j <= 4; j++) ahist[j] <= ahist[j-1];
    end
    if (k == 0) begin : g_comb
      assign rd_addr = u_if.vram_addr;
    end else begin : g_reg
      assign rd_addr = ahist[k];
    end
    assign u_if.vram_data = mem[rd_addr];

    vga_scanout #(
      .RD_LAT   (k + 1),
      .FG       (TB_FG),
      .BG       (TB_BG)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .x        (x),
      .y        (y),
      .vidon    (vidon),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .vram     (u_if),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .hsync    (hsync),
      .vsync    (vsync)
    );

    assign obs[k]      = {red, green, blue, hsync, vsync};
    assign addr_obs[k] = u_if.vram_addr;
  end

  task automatic check(input string tag, input int k, input int xi, input int yi,
                       input logic [15:0] o, input logic [15:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s inst=%0d x=%0d y=%0d observed=%h expected=%h", tag, k, xi, yi, o, e);
    end
  endtask

  function automatic logic [9:0] golden(input int xi, input int yi, input bit von,
                                        input bit hs, input bit vs, input bit blank);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    if (von && xi < H_TOTAL && yi < V_TOTAL) begin
      if (!blank && xi < H_ACTIVE && yi < V_ACTIVE) begin
        b = mem[16'(yi * 80 + xi / 8)];
        c = b[3'(xi % 8)] ? TB_FG : TB_BG;
      end else begin
        c = TB_BG;
      end
    end
    return {c, hs, vs};
  endfunction

  task automatic cyc(input int xi, input int yi, input bit von, input bit hs,
                     input bit vs, input bit chk, input bit blank);
    logic [9:0] e;
    x        = 10'(xi);
    y        = 10'(yi);
    vidon    = von;
    hsync_in = hs;
    vsync_in = vs;
    if (chk) sb_q.push_back(golden(xi, yi, von, hs, vs, blank));
    @(posedge clk);
    #1;
    if (chk) begin
      e = sb_q.pop_front();
      for (int k = 0; k < N_INST; k++) check("pixel", k, xi, yi, 16'(obs[k]), 16'(e));
    end
  endtask

  task automatic run(input int yi, input int x0, input int x1, input bit chk, input bit blank);
    bit von;
    for (int xi = x0; xi <= x1; xi++) begin
      von = (xi < H_ACTIVE) && (yi < V_ACTIVE);
      cyc(xi, yi, von, !(xi >= 656 && xi < 752), !(yi >= 490 && yi < 492), chk, blank);
      if (chk) begin
        for (int k = 0; k < N_INST; k++) begin
          if ((yi == 0 && (xi == 0 || xi == 15)) || (yi == 286 && xi >= 322 && xi <= 326))
            check("fg_pixel", k, xi, yi, 16'(obs[k][9:2]), 16'(TB_FG));
          if (yi == 0 && xi >= 1 && xi <= 14)
            check("bg_pixel", k, xi, yi, 16'(obs[k][9:2]), 16'(TB_BG));
          if (yi == 280 && xi == 313)
            check("glyph_addr", k, xi, yi, addr_obs[k], 16'd22440);
          if ((yi == 479 && xi == 792) || (yi == 480 && xi == 799))
            check("no_fetch_addr", k, xi, yi, addr_obs[k], 16'd38399);
          if (yi == 524 && xi == 792)
            check("wrap_addr", k, xi, yi, addr_obs[k], 16'd0);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01;
    mem[1] = 8'h80;
    glyph = '{8'h7c, 8'h86, 8'h8a, 8'h92, 8'ha2, 8'hc2, 8'h7c};
    for (int i = 0; i < 7; i++) mem[(280 + i) * 80 + 40] = glyph[i];

    resetn   = 1'b0;
    x        = 10'd0;
    y        = 10'd0;
    vidon    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N_INST; k++) begin
      check("reset_out", k, 0, 0, 16'(obs[k]), 16'(10'b0000000011));
      check("reset_addr", k, 0, 0, addr_obs[k], 16'd0);
    end
    resetn = 1'b1;

    // glyph rows 280..286
    run(279, 776, 799, 1'b0, 1'b0);
    for (int yi = 280; yi <= 286; yi++) run(yi, 0, 799, 1'b1, 1'b0);

    // last visible line, first blank line, then frame wrap into line 0
    run(478, 776, 799, 1'b0, 1'b0);
    run(479, 0, 799, 1'b1, 1'b0);
    run(480, 0, 799, 1'b1, 1'b0);
    run(524, 776, 799, 1'b1, 1'b0);
    run(0, 0, 799, 1'b1, 1'b0);

    // asynchronous reset mid-line
    run(99, 776, 799, 1'b0, 1'b0);
    run(100, 0, 332, 1'b1, 1'b0);
    x        = 10'd333;
    y        = 10'd100;
    vidon    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < N_INST; k++) begin
      check("reset_async", k, 333, 100, 16'(obs[k]), 16'(10'b0000000011));
      check("reset_async_addr", k, 333, 100, addr_obs[k], 16'd0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N_INST; k++)
      check("reset_hold", k, 333, 100, 16'(obs[k]), 16'(10'b0000000011));
    resetn = 1'b1;
    run(100, 334, 799, 1'b1, 1'b1);
    run(101, 0, 799, 1'b1, 1'b0);

    // vidon low over real data, random syncs
    for (int xi = 0; xi < 200; xi++)
      cyc(xi, 102, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);

    // out-of-range coordinates with vidon high
    cyc(900, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1000, 10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(10, 600, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(17, 1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Pixel-pipeline stage between the 640x480 timing generator and the board RGB/sync pins.
- Reads the 1-bpp frame buffer (80 bytes per line, 480 lines) through the video port of vram and keeps one byte in flight ahead of the beam.
- Serialises each byte into 8 pixels and maps 1/0 to foreground/background colour.
- Delays hsync/vsync so they stay aligned with the registered RGB.
- Uses a running line-base register instead of a y*80 multiplier.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line (x counts 0..H_TOTAL-1)
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame (y counts 0..V_TOTAL-1)
- BYTES_PER_LINE, 80, equal to H_ACTIVE/8
- RD_LAT, 1, vram read latency in clk cycles; legal range 1..5
- FG, 8'hFF, {r3,g3,b2} colour for a 1 bit
- BG, 8'h00, {r3,g3,b2} colour for a 0 bit

Ports:
- clk  in  1  pixel clock (clk25); vram video port is on the same clock
- resetn  in  1  asynchronous, active-low reset
- x  in  10  current pixel column from the timing generator
- y  in  10  current line from the timing generator
- vidon  in  1  active-video flag from the timing generator
- hsync_in  in  1  hsync from the timing generator, active low
- vsync_in  in  1  vsync from the timing generator, active low
- vram_addr  out  16  byte address to vram port B (registered)
- vram_data  in  8  byte returned RD_LAT cycles after vram_addr
- red  out  3  registered pixel colour
- green  out  3  registered pixel colour
- blue  out  2  registered pixel colour
- hsync  out  1  hsync_in delayed 1 clk
- vsync  out  1  vsync_in delayed 1 clk

Behaviour:
- Reset values, applied asynchronously while resetn=0:
  - red/green/blue = 0
  - hsync = vsync = 1 (inactive)
  - vram_addr = 0, line_base = 0, next_line_base = 0
  - shift register = 0, next-byte register = 0, fetch-valid pipeline = 0
- Release is synchronous to clk. Reset mid-frame: the remainder of the current line shows BG. Fetching resumes at the next x=H_TOTAL-8 slot; the first full line after reset is correct.
- Pixel order: bit i of a byte is the pixel at x[2:0]=i (LSB leftmost).
- Output latency is 1 clk:
  - red/green/blue at cycle t+1 = FG or BG, chosen by cur_byte[x[2:0]], sampled with x and vidon at cycle t.
  - Forced to 0 when vidon=0.
  - hsync/vsync are delayed by exactly 1 clk.
- Byte g (0..79) of the line is in cur_byte for every x in 8g..8g+7. cur_byte loads from next_byte on the clock edge where x[2:0]=7.
- Mid-line fetch:
  - When x=8g+1, g=0..78, and y<V_ACTIVE: drive vram_addr = line_base + g + 1 and set a valid bit in an RD_LAT-deep pipe.
  - When the pipe output is valid, capture vram_data into next_byte.
  - This completes by x=8g+1+RD_LAT, which is ≤8g+6.
- Next-line fetch:
  - When x=H_TOTAL-8, compute row r = (y==V_TOTAL-1) ? 0 : y+1.
  - If r<V_ACTIVE, fetch address next_line_base and capture as above.
  - Otherwise capture 8'h00.
- Line base:
  - next_line_base = base of row r.
  - On the edge where x=H_TOTAL-1: line_base ← next_line_base.
  - If r<V_ACTIVE-1, next_line_base ← next_line_base + BYTES_PER_LINE.
  - If y==V_TOTAL-1, both line_base and next_line_base wrap so that row 0 → 0 and row 1 → 80.
  - Maximum address is 479*80+79 = 38399; no wrap inside the 16-bit field.
- In blanking (x ≥ H_ACTIVE, except the next-line slot, or y ≥ V_ACTIVE): vram_addr holds its last value and no capture occurs.
- Inputs are out of range (x ≥ H_TOTAL or y ≥ V_TOTAL): behave as blanking; no fetch, outputs 0.
- Simultaneous x[2:0]=7 load and a capture in the same cycle cannot occur for RD_LAT ≤5; a compile-time check rejects RD_LAT outside 1..5.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, BYTES_PER_LINE) and the {r3,g3,b2} colour-field offsets; vga_640x480 uses the same package.
- One sub-module is natural: scan_fetch.
  - Owns line_base, next_line_base, vram_addr, the valid pipe and next_byte.
- The top of vga_scanout keeps cur_byte, the colour mux and the sync delay.

Test Plan:
- Preload byte 0 = 8'h01 and byte 1 = 8'h80, run line 0 with RD_LAT=1 → pixel x=0 and x=15 are FG, x=1..14 are BG; each appears 1 clk after the corresponding x.
- Load the glyph pattern 7c,86,8a,92,a2,c2,7c at rows 280..286, column byte 40 → vram_addr=22440 at the row-280 fetch; row 286, x=322..326 are FG.
- Sweep RD_LAT=1..5 with a random frame buffer → output frame is identical to the golden model for all RD_LAT values.
- Frame wrap: y=524, x=792 → vram_addr=0; at y=0, x=0 the pixel is from byte 0. At y=479, x=792 no fetch occurs and line 480 is all 0.
- Assert resetn=0 at y=100, x=333 → next edge shows RGB=0 and hsync=vsync=1. After release, line 101 is correct.
- vidon=0 with nonzero vram data → RGB=0; hsync/vsync track the inputs delayed by 1 clk.
